// File: rtl/layer_output_collector_if.sv
// Bundle between the activation stage / layer controller and the output
// collector, including the layer-buffer memory write port.
//
//   start, base_addr, layer_size : layer command (controller -> collector)
//   in_values, in_valid, in_ready: parallel lane word handshake
//   wr_en, wr_addr, wr_data      : single-port memory write strobe
//   busy, done, dropped, overflow: layer status back to the controller
//
// modport master : the side that issues commands and supplies lane words
// modport slave  : the collector itself
interface layer_output_collector_if #(
  parameter int NUM_NEURON    = 6,
  parameter int VALUE_SIZE    = 8,
  parameter int MEM_ADDR_SIZE = 10
);
  logic                             start;
  logic [MEM_ADDR_SIZE-1:0]         base_addr;
  logic [MEM_ADDR_SIZE-1:0]         layer_size;
  logic [NUM_NEURON*VALUE_SIZE-1:0] in_values;
  logic [NUM_NEURON-1:0]            in_valid;
  logic                             in_ready;
  logic                             wr_en;
  logic [MEM_ADDR_SIZE-1:0]         wr_addr;
  logic [VALUE_SIZE-1:0]            wr_data;
  logic                             busy;
  logic                             done;
  logic                             dropped;
  logic                             overflow;

  modport master (
    output start, base_addr, layer_size, in_values, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, dropped, overflow
  );

  modport slave (
    input  start, base_addr, layer_size, in_values, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, dropped, overflow
  );
endinterface

// File: rtl/layer_output_collector.sv
// layer_output_collector
//
// Serialises the parallel activated outputs of one layer into sequential
// writes to the layer buffer memory. A word of NUM_NEURON lanes with per-lane
// valid bits is captured, then its valid lanes are written one per cycle in
// ascending lane order to consecutive addresses starting at base_addr.
// After layer_size writes the block pulses done and returns to idle.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset; abandons any layer in flight
//   bus  - layer_output_collector_if.slave (command, lane word handshake,
//          memory write port, status flags)
//
// All outputs come from registers or are decoded from registered state, so
// there is no combinational path from any input to any output.
module layer_output_collector #(
  parameter int NUM_NEURON    = 6,
  parameter int VALUE_SIZE    = 8,
  parameter int MEM_ADDR_SIZE = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  layer_output_collector_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                   state_reg, state_next;
  logic [MEM_ADDR_SIZE-1:0] ptr_reg, ptr_next;
  logic [MEM_ADDR_SIZE-1:0] remaining_reg, remaining_next;
  logic [NUM_NEURON-1:0]    mask_reg, mask_next;
  logic                     dropped_reg, dropped_next;
  logic                     overflow_reg, overflow_next;
  logic [VALUE_SIZE-1:0]    value_reg [NUM_NEURON];

  logic                     capture;
  logic [VALUE_SIZE-1:0]    in_lane   [NUM_NEURON];
  logic [VALUE_SIZE-1:0]    lane_pick [NUM_NEURON];
  logic [NUM_NEURON-1:0]    sel_onehot;
  logic [NUM_NEURON-1:0]    mask_left;
  logic [MEM_ADDR_SIZE-1:0] remaining_dec;
  logic [VALUE_SIZE-1:0]    drain_data;
  logic                     any_valid;

  // Unpack the flat lane bus into one value per lane.
  for (genvar gi = 0; gi < NUM_NEURON; gi++) begin : g_unpack
    assign in_lane[gi] = bus.in_values[gi*VALUE_SIZE +: VALUE_SIZE];
  end

  assign any_valid = |bus.in_valid;

  // Isolate the lowest set mask bit: x & -x leaves only that bit.
  assign sel_onehot    = mask_reg & (~mask_reg + NUM_NEURON'(1));
  assign mask_left     = mask_reg & ~sel_onehot;
  assign remaining_dec = remaining_reg - MEM_ADDR_SIZE'(1);

  // One-hot AND-OR mux for the lane being drained.
  for (genvar gi = 0; gi < NUM_NEURON; gi++) begin : g_pick
    assign lane_pick[gi] = value_reg[gi] & {VALUE_SIZE{sel_onehot[gi]}};
  end

  always_comb begin
    drain_data = '0;
    for (int i = 0; i < NUM_NEURON; i++) begin
      drain_data = drain_data | lane_pick[i];
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    mask_next      = mask_reg;
    dropped_next   = dropped_reg;
    overflow_next  = overflow_reg;
    capture        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Lane words seen here belong to no layer and are simply ignored.
        if (bus.start) begin
          ptr_next       = bus.base_addr;
          remaining_next = bus.layer_size;
          dropped_next   = 1'b0;
          overflow_next  = 1'b0;
          state_next     = (bus.layer_size == '0) ? S_DONE : S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (any_valid) begin
          capture    = 1'b1;
          mask_next  = bus.in_valid;
          state_next = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // The mask is never empty here: a word is only captured when at
        // least one lane is valid, and we leave as soon as it empties.
        if (any_valid) begin
          dropped_next = 1'b1;
        end
        ptr_next       = ptr_reg + MEM_ADDR_SIZE'(1);
        remaining_next = remaining_dec;
        mask_next      = mask_left;
        if (remaining_dec == '0) begin
          // Layer is full; whatever is still pending is surplus.
          if (mask_left != '0) begin
            overflow_next = 1'b1;
          end
          mask_next  = '0;
          state_next = S_DONE;
        end else if (mask_left == '0) begin
          state_next = S_COLLECT;
        end
      end

      S_DONE: begin
        if (any_valid) begin
          dropped_next = 1'b1;
        end
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      mask_reg      <= '0;
      dropped_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      mask_reg      <= mask_next;
      dropped_reg   <= dropped_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Lane value buffer, loaded on capture only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURON; i++) begin
        value_reg[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_NEURON; i++) begin
        value_reg[i] <= in_lane[i];
      end
    end
  end

  // Outputs decoded from registered state. Address and data are forced to
  // zero when no write is in progress so the memory port is quiet.
  assign bus.in_ready = (state_reg == S_COLLECT);
  assign bus.busy     = (state_reg != S_IDLE);
  assign bus.done     = (state_reg == S_DONE);
  assign bus.wr_en    = (state_reg == S_DRAIN);
  assign bus.wr_addr  = (state_reg == S_DRAIN) ? ptr_reg : '0;
  assign bus.wr_data  = (state_reg == S_DRAIN) ? drain_data : '0;
  assign bus.dropped  = dropped_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_layer_output_collector.sv
// Self-checking bench for layer_output_collector: table-driven layers,
// hand-written multi-cycle corner cases, and randomized layers, all checked
// against a lane-by-lane reference model of the collection rules.
module tb_layer_output_collector;
  localparam int NN = 6;
  localparam int VS = 8;
  localparam int AW = 10;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  layer_output_collector_if #(.NUM_NEURON(NN), .VALUE_SIZE(VS), .MEM_ADDR_SIZE(AW)) bus ();

  layer_output_collector #(.NUM_NEURON(NN), .VALUE_SIZE(VS), .MEM_ADDR_SIZE(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [VS-1:0] data;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  bit  exp_ovf;
  int  done_cnt, done_cyc, last_wr_cyc;

  // Observe the memory port and done pulse away from the active edge.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      act_q.push_back('{addr: bus.wr_addr, data: bus.wr_data});
      last_wr_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    logic [AW-1:0]            base;
    logic [AW-1:0]            size;
    int                       nw;
    logic [2:0][NN-1:0]       v;
    logic [2:0][NN*VS-1:0]    d;
    int                       exp_writes;
    bit                       exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: walk valid lanes of each word in order; the n-th accepted
  // value goes to (base + n) mod 2^AW until size values are placed. Valid
  // lanes beyond that point are surplus.
  function automatic void model_layer(input logic [AW-1:0] base, input int size, input int nw,
                                      input logic [2:0][NN-1:0] v, input logic [2:0][NN*VS-1:0] d);
    int n;
    n = 0;
    exp_q.delete();
    exp_ovf = 0;
    for (int w = 0; w < nw && n < size; w++) begin
      for (int l = 0; l < NN; l++) begin
        if (v[w][l]) begin
          if (n < size) begin
            exp_q.push_back('{addr: AW'((int'(base) + n) % (1 << AW)), data: d[w][l*VS +: VS]});
            n++;
          end else begin
            exp_ovf = 1;
          end
        end
      end
    end
  endfunction

  task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] size);
    act_q.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.layer_size = size;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Offer one word when the collector is ready; ended=1 if the layer has
  // already finished so the word is not needed.
  task automatic present(input logic [NN-1:0] v, input logic [NN*VS-1:0] d, output bit ended);
    int n;
    n = 0;
    ended = 0;
    @(negedge clk);
    while (!bus.in_ready && bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("present_wait", (n < 100), 1);
    if (!bus.in_ready) begin
      ended = 1;
    end else begin
      bus.in_valid  = v;
      bus.in_values = d;
      @(posedge clk);
      #1 bus.in_valid = '0;
    end
  endtask

  task automatic finish_layer(input string name, input bit exp_drop);
    int n;
    int m;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_wait"}, (n < 200), 1);
    check({name, "_nwrites"}, act_q.size(), exp_q.size());
    m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      $display("%s wr %0d addr=%03h data=%02h (model %03h %02h)", name, i,
               act_q[i].addr, act_q[i].data, exp_q[i].addr, exp_q[i].data);
      check({name, "_wr"}, act_q[i], exp_q[i]);
    end
    check({name, "_done_cnt"}, done_cnt, 1);
    if (exp_q.size() > 0) check({name, "_done_timing"}, done_cyc, last_wr_cyc + 1);
    check({name, "_overflow"}, bus.overflow, exp_ovf);
    check({name, "_dropped"}, bus.dropped, exp_drop);
  endtask

  task automatic run_layer(input string name, input logic [AW-1:0] base, input logic [AW-1:0] size,
                           input int nw, input logic [2:0][NN-1:0] v, input logic [2:0][NN*VS-1:0] d);
    bit ended;
    do_start(base, size);
    model_layer(base, int'(size), nw, v, d);
    for (int w = 0; w < nw; w++) begin
      present(v[w], d[w], ended);
      if (ended) break;
    end
    finish_layer(name, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0][NN-1:0]    v;
    logic [2:0][NN*VS-1:0] d;
    bit                    ended;

    vecs[0] = '{10'h010, 10'd6, 1, {6'd0, 6'd0, 6'b111111},
                {48'd0, 48'd0, 48'h665544332211}, 6, 1'b0};
    vecs[1] = '{10'h020, 10'd4, 2, {6'd0, 6'b000010, 6'b100101},
                {48'd0, 48'hB5B4B3B2B1B0, 48'hA5A4A3A2A1A0}, 4, 1'b0};
    vecs[2] = '{10'h030, 10'd3, 1, {6'd0, 6'd0, 6'b111111},
                {48'd0, 48'd0, 48'h665544332211}, 3, 1'b1};
    vecs[3] = '{10'h3FD, 10'd5, 3, {6'b001000, 6'b110000, 6'b000011},
                {48'hC5C4C3C2C1C0, 48'hD5D4D3D2D1D0, 48'hE5E4E3E2E1E0}, 5, 1'b0};
    vecs[4] = '{10'h100, 10'd4, 2, {6'd0, 6'b011001, 6'b000111},
                {48'd0, 48'h2A2B2C2D2E2F, 48'h1A1B1C1D1E1F}, 4, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.layer_size = '0;
    bus.in_values = '0; bus.in_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                            bus.busy, bus.done, bus.dropped, bus.overflow}, 0);
    rst = 1'b0;

    // In-valid while idle must set nothing.
    bus.in_valid = 6'b000001;
    @(posedge clk);
    #1 bus.in_valid = '0;
    check("idle_valid_ignored", {bus.busy, bus.dropped, bus.wr_en}, 0);

    // Table-driven layers.
    for (int i = 0; i < 5; i++) begin
      run_layer($sformatf("vec%0d", i), vecs[i].base, vecs[i].size, vecs[i].nw, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d_tab_writes", i), act_q.size(), vecs[i].exp_writes);
      check($sformatf("vec%0d_tab_ovf", i), bus.overflow, vecs[i].exp_ovf);
    end

    // Sparse word: in_ready low for exactly the three drain cycles.
    v = {6'd0, 6'b000010, 6'b100101};
    d = {48'd0, 48'h0F0E0D0C0B0A, 48'h363534333231};
    do_start(10'h050, 10'd4);
    model_layer(10'h050, 4, 2, v, d);
    check("sparse_ready_after_start", {bus.busy, bus.in_ready}, 2'b11);
    bus.in_valid = v[0]; bus.in_values = d[0];
    @(posedge clk);
    #1 bus.in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      check("sparse_ready_low", {bus.in_ready, bus.wr_en}, 2'b01);
      @(posedge clk);
      #1;
    end
    check("sparse_ready_back", {bus.in_ready, bus.wr_en}, 2'b10);
    bus.in_valid = v[1]; bus.in_values = d[1];
    @(posedge clk);
    #1 bus.in_valid = '0;
    finish_layer("sparse", 1'b0);

    // Drop during DRAIN plus address wrap.
    v = {6'd0, 6'b000001, 6'b000111};
    d = {48'd0, 48'h0000000000AA, 48'h000000332211};
    do_start(10'h3FE, 10'd4);
    model_layer(10'h3FE, 4, 2, v, d);
    present(v[0], d[0], ended);
    bus.in_valid = 6'b111111; bus.in_values = 48'hEEEEEEEEEEEE;
    @(posedge clk);
    #1 bus.in_valid = '0;
    present(v[1], d[1], ended);
    finish_layer("drop_wrap", 1'b1);

    // Zero-size layer.
    do_start(10'h123, 10'd0);
    check("zero_done_pulse", {bus.done, bus.busy, bus.in_ready, bus.wr_en}, 4'b1100);
    @(posedge clk);
    #1;
    check("zero_idle_after", {bus.done, bus.busy}, 2'b00);
    @(negedge clk);
    check("zero_no_writes", act_q.size(), 0);
    check("zero_done_cnt", done_cnt, 1);

    // Start asserted mid-layer must not reload ptr/remaining.
    v = {6'd0, 6'b000100, 6'b000001};
    d = {48'd0, 48'h00000077_0000, 48'h0000000000_55};
    do_start(10'h100, 10'd2);
    model_layer(10'h100, 2, 2, v, d);
    present(v[0], d[0], ended);
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.base_addr = 10'h200; bus.layer_size = 10'd9;
    @(posedge clk);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("midstart_still_collect", {bus.busy, bus.in_ready}, 2'b11);
    present(v[1], d[1], ended);
    finish_layer("midstart", 1'b0);

    // Reset during DRAIN after the second write.
    do_start(10'h040, 10'd6);
    present(6'b111111, 48'h665544332211, ended);
    @(posedge clk);
    #1;
    check("rst_second_write", {bus.wr_en, bus.wr_addr}, {1'b1, 10'h041});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_outputs_zero", {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                               bus.busy, bus.done, bus.dropped, bus.overflow}, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_no_done", done_cnt, 0);
    check("rst_two_writes", act_q.size(), 2);
    v = {6'd0, 6'd0, 6'b000011};
    d = {48'd0, 48'd0, 48'h00000000BEEF};
    run_layer("post_rst", 10'h080, 10'd2, 1, v, d);

    // Randomized layers; size never exceeds the lanes offered.
    for (int r = 0; r < 20; r++) begin
      int nw;
      int total;
      logic [AW-1:0] base;
      nw = $urandom_range(1, 3);
      total = 0;
      v = '0;
      d = '0;
      for (int w = 0; w < nw; w++) begin
        v[w] = NN'($urandom_range(1, 63));
        d[w] = {16'($urandom), 32'($urandom)};
        total += $countones(v[w]);
      end
      base = AW'($urandom_range(0, 1023));
      run_layer($sformatf("rand%0d", r), base, AW'($urandom_range(1, total)), nw, v, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_output_collector.md
# layer_output_collector

Serializes the parallel activated neuron outputs of one layer into sequential writes to the layer buffer memory. Sits directly downstream of the activation/output stage: it accepts a NUM_NEURON-wide word with per-lane valid bits, then drains the valid lanes one per cycle to a single-port memory write interface at consecutive addresses. It tracks how many values the layer should produce, pulses `done` when the layer is complete, and flags dropped or surplus data.

## Interface
- `NUM_NEURON`, 6, number of parallel lanes
- `VALUE_SIZE`, 8, width of one activated value
- `MEM_ADDR_SIZE`, 10, width of memory address and of `layer_size`

- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `start`  in  1  begin a layer; sampled only in IDLE
- `base_addr`  in  MEM_ADDR_SIZE  first write address, sampled with `start`
- `layer_size`  in  MEM_ADDR_SIZE  number of values expected for this layer, sampled with `start`
- `in_values`  in  NUM_NEURON*VALUE_SIZE  lane i at bits [i*VALUE_SIZE +: VALUE_SIZE]
- `in_valid`  in  NUM_NEURON  per-lane valid
- `in_ready`  out  1  high when a word can be captured
- `wr_en`  out  1  memory write strobe
- `wr_addr`  out  MEM_ADDR_SIZE  write address
- `wr_data`  out  VALUE_SIZE  write data
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at layer completion
- `dropped`  out  1  sticky: nonzero `in_valid` arrived while `in_ready` low during a layer
- `overflow`  out  1  sticky: valid lanes remained after `layer_size` values were written

## Operation
- States: IDLE, COLLECT, DRAIN, DONE. `in_ready` = (state == COLLECT); `busy` = (state != IDLE).
- IDLE: on `start`, load `ptr` <- `base_addr`, `remaining` <- `layer_size`, clear `dropped` and `overflow`. Next state COLLECT, or DONE if `layer_size` == 0.
- COLLECT: if `in_valid` != 0, capture `in_values` into the value buffer and `in_valid` into the lane mask, then go to DRAIN. Otherwise stay.
- DRAIN: each cycle select the lowest set mask bit i. Drive `wr_en`=1, `wr_data`=lane i, `wr_addr`=`ptr`. Then `ptr`++ (wraps modulo 2^MEM_ADDR_SIZE), `remaining`--, and clear mask bit i.
  - When this is the last set mask bit and `remaining` (after decrement) > 0: next state COLLECT.
  - When `remaining` (after decrement) == 0: next state DONE. If any mask bits are still set, set `overflow` and discard them.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- Lanes are written in ascending lane index. Addresses are assigned in arrival order, so invalid lanes consume no address.
- Nonzero `in_valid` in DRAIN or DONE sets `dropped`; the data is ignored. `in_valid` in IDLE is ignored and sets nothing.
- `start` outside IDLE is ignored.
- `rst` in any state: immediately return to IDLE with all outputs 0. An in-flight layer is abandoned and no `done` is produced.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `dropped`=0, `overflow`=0; internal `ptr`, `remaining`, and mask are 0.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- `start` sampled at edge E: `busy` and `in_ready` are high from cycle E+1.
- Word captured at edge T0 with k valid lanes: `wr_en` is high during cycles T0+1 through T0+k, with consecutive `wr_addr`. `in_ready` is low during those cycles and returns high in cycle T0+k+1 (unless the layer ends).
- Last write in cycle Tw: `done` is high in cycle Tw+1; `busy` and `done` are low from Tw+2.
- `layer_size`==0: `start` at edge E gives `done` in cycle E+1, with no writes.
- Sustained throughput is one value per cycle while draining, plus one capture cycle per input word.

## Test plan
- Basic layer: `start` with `base_addr`=0x010, `layer_size`=6, then one word with `in_valid`=6'b111111 and lanes 0x11..0x66 -> six writes 0x010..0x015 of data 0x11..0x66, in order; `done` one cycle after the last write; `dropped`=`overflow`=0.
- Sparse lanes: `layer_size`=4, word1 `in_valid`=6'b100101, word2 `in_valid`=6'b000010 -> writes of lane 0, 2, 5 of word1, then lane 1 of word2, at base..base+3; `in_ready` low for exactly 3 cycles after the word1 capture.
- Overflow: `layer_size`=3, one word with `in_valid`=6'b111111 -> exactly three writes (lanes 0–2); `overflow`=1; `done` pulses; lanes 3–5 are never written.
- Drop and wrap: `base_addr`=0x3FE, `layer_size`=4, and a second valid word presented during DRAIN -> `dropped`=1; addresses written are 0x3FE, 0x3FF, 0x000, 0x001.
- Zero size and `start` while busy: `layer_size`=0 -> `done` in the cycle after `start`, no `wr_en`. A `start` asserted mid-layer is ignored, leaving `ptr` and `remaining` unchanged.
- Reset mid-DRAIN: assert `rst` after the 2nd of 6 writes -> all outputs 0 the next cycle, no `done`; a new `start` runs a clean layer from its new `base_addr`.
